// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO burst read controller.
// The stream word pairs a data word with its end-of-burst tag.
package fifo_rd_pkg;

  localparam int unsigned DefaultDataW    = 16;
  localparam int unsigned DefaultPtrW     = 3;
  localparam int unsigned DefaultBurstLen = 4;
  localparam int unsigned DefaultTimeout  = 15;

  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StDrain
  } state_e;

  typedef struct packed {
    logic [DefaultDataW-1:0] data;
    logic                    last;
  } stream_word_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus outgoing valid/ready stream of the burst reader.
// master is the reader's view; slave is the FIFO/consumer side.
interface fifo_burst_reader_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PTR_W  = 3
);

  logic              fifo_empty;
  logic [PTR_W:0]    fifo_count;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    input  fifo_empty,
    input  fifo_count,
    input  fifo_rd_data,
    input  out_ready,
    output fifo_rd_en,
    output out_valid,
    output out_data,
    output out_last
  );

  modport slave (
    output fifo_empty,
    output fifo_count,
    output fifo_rd_data,
    output out_ready,
    input  fifo_rd_en,
    input  out_valid,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry circular skid buffer; absorbs words already in flight from the
// FIFO when the consumer stalls. Occupancy is exposed for credit accounting.
module fifo_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter type word_t = stream_word_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid_i,
  input  word_t      wr_word_i,
  input  logic       pop_i,
  output word_t      head_o,
  output logic [1:0] occ_o
);

  word_t      mem_q [2];
  word_t      mem_d [2];
  logic       head_q, head_d;
  logic [1:0] occ_q, occ_d;
  logic       wr_en;
  logic       rd_en;
  logic       wr_idx;

  always_comb begin
    wr_en  = wr_valid_i && (occ_q != 2'd2);
    rd_en  = pop_i && (occ_q != 2'd0);
    // Tail slot is the head when empty, the other slot when one entry is held.
    wr_idx = head_q ^ occ_q[0];
    mem_d  = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = wr_word_i;
    end
    head_d = head_q ^ rd_en;
    occ_d  = occ_q + {1'b0, wr_en} - {1'b0, rd_en};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      head_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      occ_q  <= occ_d;
    end
  end

  assign head_o = mem_q[head_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read controller: pops the FIFO in bursts, hides its one-cycle read
// latency behind a skid buffer and tags the final beat of each burst.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned PTR_W     = DefaultPtrW,
  parameter int unsigned BURST_LEN = DefaultBurstLen,
  parameter int unsigned TIMEOUT   = DefaultTimeout
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic                busy,
  fifo_burst_reader_if.master bus
);

  localparam int unsigned CntW = PTR_W + 1;
  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t       BurstLenC  = cnt_t'(BURST_LEN);
  localparam logic [7:0] TimerLastC = 8'(TIMEOUT - 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } word_t;

  state_e     state_q, state_d;
  cnt_t       beats_left_q, beats_left_d;
  logic [7:0] timer_q, timer_d;
  logic       inflight_q;
  logic       inflight_last_q;

  logic       rd_en;
  logic       rd_last;
  logic       pop;
  logic [1:0] occ;
  cnt_t       credit;
  word_t      head;
  word_t      wr_word;

  assign pop    = bus.out_valid && bus.out_ready;
  // Words held plus words still coming back from the FIFO, after this pop.
  assign credit = cnt_t'(occ) + cnt_t'(inflight_q) - cnt_t'(pop);

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    timer_d      = 8'd0;
    rd_en        = 1'b0;
    rd_last      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && (bus.fifo_count >= BurstLenC)) begin
          state_d      = StBurst;
          beats_left_d = BurstLenC;
        end else if (enable && (bus.fifo_count != '0)) begin
          // Partial burst: flush the snapshot once the idle timer expires.
          if (timer_q == TimerLastC) begin
            state_d      = StBurst;
            beats_left_d = bus.fifo_count;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
      end
      StBurst: begin
        if ((beats_left_q != '0) && !bus.fifo_empty && (credit < cnt_t'(2))) begin
          rd_en        = 1'b1;
          beats_left_d = beats_left_q - cnt_t'(1);
          if (beats_left_q == cnt_t'(1)) begin
            rd_last = 1'b1;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if ((occ == 2'd0) && !inflight_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      beats_left_q    <= '0;
      timer_q         <= 8'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      beats_left_q    <= beats_left_d;
      timer_q         <= timer_d;
      inflight_q      <= rd_en;
      inflight_last_q <= rd_last;
    end
  end

  assign wr_word = '{data: bus.fifo_rd_data, last: inflight_last_q};

  fifo_skid_buf #(
    .word_t (word_t)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .wr_valid_i (inflight_q),
    .wr_word_i  (wr_word),
    .pop_i      (pop),
    .head_o     (head),
    .occ_o      (occ)
  );

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = (occ != 2'd0);
  assign bus.out_data   = bus.out_valid ? head.data : '0;
  assign bus.out_last   = bus.out_valid && head.last;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: FIFO model, per-cycle handshake traces
// and a scoreboard of expected {last, data} beats.
module tb_fifo_burst_reader;

  logic clk;
  logic reset;
  logic enable;
  logic busy;
  logic force_empty;

  int vectors;
  int miscompares;

  logic [15:0] fmem [$];
  logic [15:0] pend [$];
  logic [16:0] exp_q [$];

  logic [31:0] rd_bits, v_bits, busy_bits;
  logic        held_v;
  logic [31:0] held_word;

  fifo_burst_reader_if #(.DATA_W(16), .PTR_W(3)) bus ();

  fifo_burst_reader #(
    .DATA_W    (16),
    .PTR_W     (3),
    .BURST_LEN (4),
    .TIMEOUT   (15)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .busy   (busy),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous FIFO with registered read data, sharing the DUT reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fmem.delete();
      pend.delete();
      bus.fifo_rd_data <= '0;
      bus.fifo_count   <= '0;
      bus.fifo_empty   <= 1'b1;
    end else begin
      if (bus.fifo_rd_en && (fmem.size() != 0)) begin
        bus.fifo_rd_data <= fmem.pop_front();
      end
      while ((pend.size() != 0) && (fmem.size() < 8)) begin
        fmem.push_back(pend.pop_front());
      end
      bus.fifo_count <= 4'(fmem.size());
      bus.fifo_empty <= (fmem.size() == 0) || force_empty;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Stream monitor: scoreboard compare, stall stability, no pop while empty.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.fifo_rd_en) chk("rd_en_while_empty", 32'(bus.fifo_empty), 32'd0);
      if (held_v && bus.out_valid) begin
        chk("stall_stable", {15'd0, bus.out_last, bus.out_data}, held_word);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("beat", {15'd0, bus.out_last, bus.out_data}, {15'd0, exp_q.pop_front()});
        end
      end
      held_v    = bus.out_valid && !bus.out_ready;
      held_word = {15'd0, bus.out_last, bus.out_data};
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic wr(input logic [15:0] d, input logic last);
    pend.push_back(d);
    exp_q.push_back({last, d});
  endtask

  task automatic wr4(input logic [15:0] base);
    for (int i = 1; i <= 4; i++) wr(base + 16'(i), i == 4);
  endtask

  task automatic clear_trace();
    rd_bits   = '0;
    v_bits    = '0;
    busy_bits = '0;
  endtask

  // Bit i of each trace = value in cycle i, cycle 0 being the current one.
  task automatic capture(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd_bits[5'(start + i)]   = bus.fifo_rd_en;
      v_bits[5'(start + i)]    = bus.out_valid;
      busy_bits[5'(start + i)] = busy;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_data"}, 32'(bus.out_data), 32'd0);
    chk({tag, "_last"}, 32'(bus.out_last), 32'd0);
    chk({tag, "_rd_en"}, 32'(bus.fifo_rd_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    held_v        = 1'b0;
    held_word     = '0;
    reset         = 1'b0;
    enable        = 1'b0;
    force_empty   = 1'b0;
    bus.out_ready = 1'b1;

    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Full burst, consumer always ready.
    clear_trace();
    enable = 1'b1;
    wr4(16'hA000);
    capture(0, 16);
    chk("t1_rd", rd_bits, 32'h0000_003C);
    chk("t1_valid", v_bits, 32'h0000_00F0);
    chk("t1_busy", busy_bits, 32'h0000_01FC);

    // Partial burst flushed by the idle timer.
    clear_trace();
    wr(16'hB001, 1'b0);
    wr(16'hB002, 1'b1);
    capture(0, 24);
    chk("t2_rd", rd_bits, 32'h0003_0000);
    chk("t2_valid", v_bits, 32'h000C_0000);
    chk("t2_busy", busy_bits, 32'h001F_0000);

    // Consumer stalls until 10 cycles after the first beat.
    clear_trace();
    bus.out_ready = 1'b0;
    wr4(16'hC000);
    capture(0, 14);
    bus.out_ready = 1'b1;
    capture(14, 10);
    chk("t3_rd", rd_bits, 32'h0000_C00C);
    chk("t3_valid", v_bits, 32'h0003_FFF0);

    // FIFO reports empty for 5 cycles after the second pop.
    clear_trace();
    wr4(16'hE000);
    capture(0, 3);
    force_empty = 1'b1;
    capture(3, 5);
    force_empty = 1'b0;
    capture(8, 8);
    chk("t4_rd", rd_bits, 32'h0000_060C);
    chk("t4_valid", v_bits, 32'h0000_1830);

    // Reset during the second beat, then a clean burst.
    clear_trace();
    wr4(16'hF000);
    capture(0, 5);
    reset = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    exp_q.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    clear_trace();
    wr4(16'h6000);
    capture(0, 16);
    chk("t5_rd", rd_bits, 32'h0000_003C);
    chk("t5_valid", v_bits, 32'h0000_00F0);
    chk("t5_busy", busy_bits, 32'h0000_01FC);

    // Disabled with a full FIFO, then enable dropped mid-burst.
    clear_trace();
    enable = 1'b0;
    wr4(16'h7000);
    wr4(16'h7004);
    capture(0, 20);
    chk("t6_off_rd", rd_bits, 32'h0000_0000);
    chk("t6_off_busy", busy_bits, 32'h0000_0000);
    clear_trace();
    enable = 1'b1;
    capture(0, 2);
    enable = 1'b0;
    capture(2, 20);
    chk("t6_rd", rd_bits, 32'h0000_001E);
    chk("t6_valid", v_bits, 32'h0000_0078);
    clear_trace();
    enable = 1'b1;
    capture(0, 12);
    chk("t6_rest_rd", rd_bits, 32'h0000_001E);
    chk("t6_rest_valid", v_bits, 32'h0000_0078);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
